// File: rtl/riscv_pkg.sv
// Shared RISC-V CSR types: command encoding, address type and Zicsr funct3 codes.
package riscv_pkg;

   localparam int MXLEN = 64;

   typedef logic [11:0] csr_address_t;

   typedef enum logic [1:0] {
      NO_COMMAND     = 2'd0,
      READ_ONLY      = 2'd1,
      WRITE_ONLY     = 2'd2,
      WRITE_AND_READ = 2'd3
   } csr_command_t;

   typedef enum logic [2:0] {
      CSRRW  = 3'b001,
      CSRRS  = 3'b010,
      CSRRC  = 3'b011,
      CSRRWI = 3'b101,
      CSRRSI = 3'b110,
      CSRRCI = 3'b111
   } csr_funct3_t;

endpackage

// File: rtl/csr_access_unit_if.sv
// Execute-stage request/response and CSR-file bus signals of the CSR access unit.
interface csr_access_unit_if #(
   parameter int MXLEN = riscv_pkg::MXLEN
) ();

   logic                     req_valid_i;
   logic                     req_ready_o;
   logic [2:0]               req_funct3_i;
   riscv_pkg::csr_address_t  req_address_i;
   logic [MXLEN-1:0]         req_rs1_data_i;
   logic [4:0]               req_uimm_i;
   logic                     req_rd_zero_i;
   logic                     rsp_valid_o;
   logic                     rsp_ready_i;
   logic [MXLEN-1:0]         rsp_data_o;
   logic                     rsp_illegal_o;
   riscv_pkg::csr_address_t  csr_address_o;
   riscv_pkg::csr_command_t  csr_command_o;
   logic [MXLEN-1:0]         csr_write_data_o;
   logic [MXLEN-1:0]         csr_read_data_i;
   logic                     csr_read_data_valid_i;

   modport slave (
      input  req_valid_i, req_funct3_i, req_address_i, req_rs1_data_i, req_uimm_i,
             req_rd_zero_i, rsp_ready_i, csr_read_data_i, csr_read_data_valid_i,
      output req_ready_o, rsp_valid_o, rsp_data_o, rsp_illegal_o,
             csr_address_o, csr_command_o, csr_write_data_o
   );

   modport master (
      output req_valid_i, req_funct3_i, req_address_i, req_rs1_data_i, req_uimm_i,
             req_rd_zero_i, rsp_ready_i, csr_read_data_i, csr_read_data_valid_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_illegal_o,
             csr_address_o, csr_command_o, csr_write_data_o
   );

endinterface

// File: rtl/csr_access_unit_rmw_alu.sv
// Read-modify-write data for CSRRW/S/C: new value from the old CSR value and the source operand.
module csr_rmw_alu
   import riscv_pkg::*;
#(
   parameter int MXLEN = 64
) (
   input  logic [2:0]       funct3_i,
   input  logic [MXLEN-1:0] old_i,
   input  logic [MXLEN-1:0] src_i,
   output logic [MXLEN-1:0] wdata_o
);

   always_comb begin
      wdata_o = src_i;
      case (funct3_i)
         CSRRS, CSRRSI: wdata_o = old_i | src_i;
         CSRRC, CSRRCI: wdata_o = old_i & ~src_i;
         default:       wdata_o = src_i;
      endcase
   end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr initiator: sequences read / read-modify-write on the CSR bus and returns the old value.
// Optional CSR_SINGLE_CYCLE_RW_EN: CSRRW/CSRRWI with rd!=x0 use one WRITE_AND_READ cycle.
module csr_access_unit
   import riscv_pkg::*;
#(
   parameter int MXLEN = riscv_pkg::MXLEN
) (
   input logic         clock_i,
   input logic         reset_ni,
   csr_access_unit_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [MXLEN-1:0] old_q, old_d;
   logic [MXLEN-1:0] src_q, src_d;
   csr_address_t     addr_q;
   logic [2:0]       funct3_q;
   logic             wintent_q, wintent_d;
   logic             accept;
   logic             is_rw_d;
   logic             illegal_early;
   logic [MXLEN-1:0] wdata;
   csr_command_t     command;
`ifdef CSR_SINGLE_CYCLE_RW_EN
   logic             rw_read_q;
`endif

   assign accept  = (state_q == S_IDLE) && bus.req_valid_i;
   assign is_rw_d = (bus.req_funct3_i[1:0] == 2'b01);
   assign src_d   = bus.req_funct3_i[2] ? {{(MXLEN-5){1'b0}}, bus.req_uimm_i}
                                        : bus.req_rs1_data_i;
   assign wintent_d = is_rw_d || (src_d != '0);
   // Unused funct3 codes, or any write to the read-only address quadrant, fail before the bus.
   assign illegal_early = (bus.req_funct3_i[1:0] == 2'b00) ||
                          (wintent_d && (bus.req_address_i[11:10] == 2'b11));

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      old_d     = old_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid_i) begin
               illegal_d = illegal_early;
               old_d     = '0;
               if (illegal_early) begin
                  state_d = S_RESP;
`ifdef CSR_SINGLE_CYCLE_RW_EN
               end else if (is_rw_d) begin
`else
               end else if (is_rw_d && bus.req_rd_zero_i) begin
`endif
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            if (!bus.csr_read_data_valid_i) begin
               illegal_d = 1'b1;
               state_d   = S_RESP;
            end else begin
               old_d   = bus.csr_read_data_i;
               state_d = wintent_q ? S_WRITE : S_RESP;
            end
         end
         S_WRITE: begin
            // The CSR file drops the write itself when the access is invalid.
            if (!bus.csr_read_data_valid_i) begin
               illegal_d = 1'b1;
            end
`ifdef CSR_SINGLE_CYCLE_RW_EN
            else if (rw_read_q) begin
               old_d = bus.csr_read_data_i;
            end
`endif
            state_d = S_RESP;
         end
         default: begin
            if (bus.rsp_ready_i) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         state_q   <= S_IDLE;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_ff @(posedge clock_i) begin
      old_q <= old_d;
      if (accept) begin
         addr_q    <= bus.req_address_i;
         funct3_q  <= bus.req_funct3_i;
         src_q     <= src_d;
         wintent_q <= wintent_d;
`ifdef CSR_SINGLE_CYCLE_RW_EN
         rw_read_q <= is_rw_d && !bus.req_rd_zero_i;
`endif
      end
   end

   csr_rmw_alu #(.MXLEN(MXLEN)) u_rmw_alu (
      .funct3_i (funct3_q),
      .old_i    (old_q),
      .src_i    (src_q),
      .wdata_o  (wdata)
   );

   always_comb begin
      command = NO_COMMAND;
      case (state_q)
         S_READ:  command = READ_ONLY;
`ifdef CSR_SINGLE_CYCLE_RW_EN
         S_WRITE: command = rw_read_q ? WRITE_AND_READ : WRITE_ONLY;
`else
         S_WRITE: command = WRITE_ONLY;
`endif
         default: command = NO_COMMAND;
      endcase
   end

   // Bus and response outputs are forced to zero outside their active states.
   assign bus.csr_command_o    = command;
   assign bus.csr_address_o    = (state_q == S_READ || state_q == S_WRITE) ? addr_q : '0;
   assign bus.csr_write_data_o = (state_q == S_WRITE) ? wdata : '0;
   assign bus.req_ready_o      = (state_q == S_IDLE);
   assign bus.rsp_valid_o      = (state_q == S_RESP);
   assign bus.rsp_illegal_o    = (state_q == S_RESP) && illegal_q;
   assign bus.rsp_data_o       = (state_q == S_RESP && !illegal_q) ? old_q : '0;

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: directed table, corner sequences and random traffic.
module tb_csr_access_unit;
   import riscv_pkg::*;

`ifdef CSR_SINGLE_CYCLE_RW_EN
   localparam bit SINGLE = 1'b1;
   localparam int RW_LAT = 2;
`else
   localparam bit SINGLE = 1'b0;
   localparam int RW_LAT = 3;
`endif

   typedef struct {
      int              lat;
      logic [63:0]     data;
      bit              ill;
      logic [63:0]     newv;
      int              ntr;
      logic [1:0][1:0] tcmd;
      logic [1:0][63:0] twd;
      bit              rdy_busy;
      bit              badaddr;
      bit              ready_after;
   } res_t;

   typedef struct {
      logic [2:0]  f3;
      logic [11:0] a;
      logic [63:0] rs1;
      logic [4:0]  uimm;
      bit          rdz;
      logic [63:0] pre;
      logic [63:0] d;
      bit          ill;
      int          lat;
      logic [63:0] nv;
   } vec_t;

   logic clock_i = 1'b0;
   logic reset_ni = 1'b0;
   int   tests = 0;
   int   fails = 0;

   logic [63:0] csr_mem    [0:4095];
   bit          csr_exists [0:4095];

   csr_access_unit_if #(.MXLEN(64)) bus ();

   csr_access_unit #(.MXLEN(64)) dut (
      .clock_i  (clock_i),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   always #5 clock_i = ~clock_i;

   assign bus.csr_read_data_i       = csr_mem[bus.csr_address_o];
   assign bus.csr_read_data_valid_i = csr_exists[bus.csr_address_o];

   always @(posedge clock_i) begin
      if ((bus.csr_command_o == WRITE_ONLY || bus.csr_command_o == WRITE_AND_READ) &&
          csr_exists[bus.csr_address_o])
         csr_mem[bus.csr_address_o] <= bus.csr_write_data_o;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: outcome of one Zicsr instruction given the CSR's current value and existence.
   function automatic res_t model(input logic [2:0] f3, input logic [11:0] a,
                                  input logic [63:0] rs1, input logic [4:0] uimm,
                                  input bit rdz, input logic [63:0] cur, input bit ex);
      res_t e;
      logic [63:0] src;
      bit wi;
      e = '{default: 0};
      e.ready_after = 1'b1;
      e.newv = cur;
      src = f3[2] ? {59'd0, uimm} : rs1;
      wi = (f3[1:0] == 2'b01) || (src != 64'd0);
      if (f3[1:0] == 2'b00 || (wi && a[11:10] == 2'b11)) begin
         e.ill = 1'b1; e.lat = 1;
      end else if (f3[1:0] == 2'b01 && (rdz || SINGLE)) begin
         e.ntr = 1; e.lat = 2;
         e.tcmd[0] = rdz ? WRITE_ONLY : WRITE_AND_READ;
         e.twd[0] = src;
         e.ill = !ex;
         e.data = (!ex || rdz) ? 64'd0 : cur;
         if (ex) e.newv = src;
      end else begin
         e.ntr = 1; e.lat = 2;
         e.tcmd[0] = READ_ONLY;
         if (!ex) begin
            e.ill = 1'b1;
         end else begin
            e.data = cur;
            if (wi) begin
               e.ntr = 2; e.lat = 3;
               e.tcmd[1] = WRITE_ONLY;
               case (f3[1:0])
                  2'b01:   e.twd[1] = src;
                  2'b10:   e.twd[1] = cur | src;
                  default: e.twd[1] = cur & ~src;
               endcase
               e.newv = e.twd[1];
            end
         end
      end
      return e;
   endfunction

   // Starts at a falling edge with the unit idle; ends at the falling edge after the response.
   task automatic run(input logic [2:0] f3, input logic [11:0] a, input logic [63:0] rs1,
                      input logic [4:0] uimm, input bit rdz, output res_t o);
      o = '{default: 0};
      o.lat = 99;
      bus.rsp_ready_i    = 1'b1;
      bus.req_valid_i    = 1'b1;
      bus.req_funct3_i   = f3;
      bus.req_address_i  = a;
      bus.req_rs1_data_i = rs1;
      bus.req_uimm_i     = uimm;
      bus.req_rd_zero_i  = rdz;
      @(posedge clock_i);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clock_i);
         if (bus.req_ready_o) o.rdy_busy = 1'b1;
         if (bus.csr_command_o != NO_COMMAND) begin
            if (bus.csr_address_o != a) o.badaddr = 1'b1;
            if (o.ntr < 2) begin
               o.tcmd[o.ntr] = bus.csr_command_o;
               o.twd[o.ntr]  = bus.csr_write_data_o;
            end
            o.ntr++;
         end
         if (bus.rsp_valid_o) begin
            o.lat  = c;
            o.data = bus.rsp_data_o;
            o.ill  = bus.rsp_illegal_o;
            o.newv = csr_mem[a];
            break;
         end
         bus.req_valid_i    = 1'b1;
         bus.req_funct3_i   = 3'($urandom);
         bus.req_address_i  = 12'($urandom);
         bus.req_rs1_data_i = {$urandom, $urandom};
         bus.req_uimm_i     = 5'($urandom);
         bus.req_rd_zero_i  = 1'($urandom);
      end
      bus.req_valid_i = 1'b0;
      @(negedge clock_i);
      o.ready_after = bus.req_ready_o && !bus.rsp_valid_o;
   endtask

   task automatic compare(input string n, input res_t o, input res_t e);
      chk({n, ".lat"}, o.lat, e.lat);
      chk({n, ".data"}, o.data, e.data);
      chk({n, ".illegal"}, o.ill, e.ill);
      chk({n, ".csr"}, o.newv, e.newv);
      chk({n, ".ncmd"}, o.ntr, e.ntr);
      chk({n, ".ready_busy"}, o.rdy_busy, 1'b0);
      chk({n, ".addr"}, o.badaddr, 1'b0);
      chk({n, ".ready_after"}, o.ready_after, 1'b1);
      for (int k = 0; k < e.ntr && k < 2; k++) begin
         chk($sformatf("%s.cmd%0d", n, k), o.tcmd[k], e.tcmd[k]);
         if (e.tcmd[k] != READ_ONLY)
            chk($sformatf("%s.wdata%0d", n, k), o.twd[k], e.twd[k]);
      end
   endtask

   initial begin
      vec_t vecs [14];
      res_t o, e;
      bit   found;
      logic [11:0] pool [8];

      for (int i = 0; i < 4096; i++) begin
         csr_mem[i] = 64'd0;
         csr_exists[i] = 1'b0;
      end
      csr_exists[12'h340] = 1'b1; csr_exists[12'h304] = 1'b1; csr_exists[12'h305] = 1'b1;
      csr_exists[12'h300] = 1'b1; csr_exists[12'hC00] = 1'b1; csr_exists[12'hF14] = 1'b1;

      vecs[0]  = '{3'b001, 12'h340, 64'hDEADBEEF, 5'h00, 1'b0, 64'h5,    64'h5,    1'b0, RW_LAT, 64'hDEADBEEF};
      vecs[1]  = '{3'b010, 12'h304, 64'h0,        5'h00, 1'b0, 64'h888,  64'h888,  1'b0, 2,      64'h888};
      vecs[2]  = '{3'b111, 12'h304, 64'h0,        5'h08, 1'b0, 64'h888,  64'h888,  1'b0, 3,      64'h880};
      vecs[3]  = '{3'b001, 12'hC00, 64'h1,        5'h00, 1'b0, 64'h1234, 64'h0,    1'b1, 1,      64'h1234};
      vecs[4]  = '{3'b010, 12'h7C0, 64'hFF,       5'h00, 1'b0, 64'h0,    64'h0,    1'b1, 2,      64'h0};
      vecs[5]  = '{3'b101, 12'h305, 64'hFFFFFFFF, 5'h1C, 1'b0, 64'h100,  64'h100,  1'b0, RW_LAT, 64'h1C};
      vecs[6]  = '{3'b001, 12'h340, 64'h77,       5'h00, 1'b1, 64'h5,    64'h0,    1'b0, 2,      64'h77};
      vecs[7]  = '{3'b000, 12'h340, 64'h1,        5'h00, 1'b0, 64'h5,    64'h0,    1'b1, 1,      64'h5};
      vecs[8]  = '{3'b100, 12'h340, 64'h1,        5'h00, 1'b0, 64'h5,    64'h0,    1'b1, 1,      64'h5};
      vecs[9]  = '{3'b010, 12'hC00, 64'h0,        5'h00, 1'b0, 64'hABC,  64'hABC,  1'b0, 2,      64'hABC};
      vecs[10] = '{3'b110, 12'h300, 64'h0,        5'h1F, 1'b0, 64'h100,  64'h100,  1'b0, 3,      64'h11F};
      vecs[11] = '{3'b011, 12'h300, 64'hF0F0,     5'h00, 1'b0, 64'hFFFF, 64'hFFFF, 1'b0, 3,      64'h0F0F};
      vecs[12] = '{3'b110, 12'hC00, 64'h0,        5'h00, 1'b0, 64'hABC,  64'hABC,  1'b0, 2,      64'hABC};
      vecs[13] = '{3'b001, 12'hC00, 64'h5,        5'h00, 1'b1, 64'hABC,  64'h0,    1'b1, 1,      64'hABC};

      bus.req_valid_i = 1'b0; bus.req_funct3_i = 3'd0; bus.req_address_i = 12'd0;
      bus.req_rs1_data_i = 64'd0; bus.req_uimm_i = 5'd0; bus.req_rd_zero_i = 1'b0;
      bus.rsp_ready_i = 1'b1;

      repeat (3) @(posedge clock_i);
      @(negedge clock_i);
      chk("reset.req_ready", bus.req_ready_o, 1'b1);
      chk("reset.rsp_valid", bus.rsp_valid_o, 1'b0);
      chk("reset.rsp_illegal", bus.rsp_illegal_o, 1'b0);
      chk("reset.rsp_data", bus.rsp_data_o, 64'd0);
      chk("reset.command", bus.csr_command_o, NO_COMMAND);
      chk("reset.address", bus.csr_address_o, 12'd0);
      chk("reset.wdata", bus.csr_write_data_o, 64'd0);
      reset_ni = 1'b1;
      @(negedge clock_i);

      for (int i = 0; i < 14; i++) begin
         csr_mem[vecs[i].a] = vecs[i].pre;
         e = model(vecs[i].f3, vecs[i].a, vecs[i].rs1, vecs[i].uimm, vecs[i].rdz,
                   vecs[i].pre, csr_exists[vecs[i].a]);
         e.lat = vecs[i].lat; e.data = vecs[i].d; e.ill = vecs[i].ill; e.newv = vecs[i].nv;
         run(vecs[i].f3, vecs[i].a, vecs[i].rs1, vecs[i].uimm, vecs[i].rdz, o);
         compare($sformatf("vec%0d", i), o, e);
      end

      // Response held while rsp_ready_i is low.
      csr_mem[12'h304] = 64'h888;
      bus.rsp_ready_i = 1'b0;
      bus.req_valid_i = 1'b1; bus.req_funct3_i = 3'b010; bus.req_address_i = 12'h304;
      bus.req_rs1_data_i = 64'd0; bus.req_rd_zero_i = 1'b0;
      @(posedge clock_i);
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
         @(negedge clock_i);
         bus.req_valid_i = 1'b0;
         found = bus.rsp_valid_o;
      end
      chk("hold.wait_rsp", found, 1'b1);
      for (int c = 0; c < 4; c++) begin
         if (c != 0) @(negedge clock_i);
         chk($sformatf("hold%0d.rsp_valid", c), bus.rsp_valid_o, 1'b1);
         chk($sformatf("hold%0d.rsp_data", c), bus.rsp_data_o, 64'h888);
         chk($sformatf("hold%0d.rsp_illegal", c), bus.rsp_illegal_o, 1'b0);
         chk($sformatf("hold%0d.req_ready", c), bus.req_ready_o, 1'b0);
      end
      bus.rsp_ready_i = 1'b1;
      @(negedge clock_i);
      chk("hold.release_valid", bus.rsp_valid_o, 1'b0);
      chk("hold.release_ready", bus.req_ready_o, 1'b1);

      // Reset asserted while the unit drives a write.
      bus.req_valid_i = 1'b1; bus.req_funct3_i = 3'b001; bus.req_address_i = 12'h340;
      bus.req_rs1_data_i = 64'h55; bus.req_rd_zero_i = 1'b0;
      @(posedge clock_i);
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
         @(negedge clock_i);
         bus.req_valid_i = 1'b0;
         found = (bus.csr_command_o == WRITE_ONLY || bus.csr_command_o == WRITE_AND_READ);
      end
      chk("rst_mid.wait_write", found, 1'b1);
      reset_ni = 1'b0;
      @(negedge clock_i);
      chk("rst_mid.command", bus.csr_command_o, NO_COMMAND);
      chk("rst_mid.rsp_valid", bus.rsp_valid_o, 1'b0);
      chk("rst_mid.req_ready", bus.req_ready_o, 1'b1);
      chk("rst_mid.address", bus.csr_address_o, 12'd0);
      reset_ni = 1'b1;
      @(negedge clock_i);
      chk("rst_mid.idle_cmd", bus.csr_command_o, NO_COMMAND);
      chk("rst_mid.idle_valid", bus.rsp_valid_o, 1'b0);

      pool[0] = 12'h340; pool[1] = 12'h304; pool[2] = 12'h305; pool[3] = 12'h300;
      pool[4] = 12'hC00; pool[5] = 12'h7C0; pool[6] = 12'hF14;
      for (int i = 0; i < 4096; i++)
         if (csr_exists[i]) csr_mem[i] = {$urandom, $urandom};
      for (int i = 0; i < 300; i++) begin
         logic [2:0]  f3;
         logic [11:0] a;
         logic [63:0] rs1;
         logic [4:0]  uimm;
         bit          rdz;
         pool[7] = 12'($urandom);
         f3   = 3'($urandom_range(0, 7));
         a    = pool[$urandom_range(0, 7)];
         rs1  = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
         uimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         rdz  = 1'($urandom);
         e = model(f3, a, rs1, uimm, rdz, csr_mem[a], csr_exists[a]);
         run(f3, a, rs1, uimm, rdz, o);
         compare($sformatf("rand%0d", i), o, e);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
